// File: rtl/sub_serial_cmp_pkg.sv
// Shared types and constants for the serial subtractor-comparator.
// The formatter uses GT/EQ/LT to pack the flags; steps() sizes the digit loop.
package sub_serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned GT = 0;
    localparam int unsigned EQ = 1;
    localparam int unsigned LT = 2;

    // Number of DIGIT-wide slices needed to cover the sign-extended operand.
    function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
        if (digit == 0) return 1;
        return (width + digit) / digit;
    endfunction

endpackage

// File: rtl/sub_digit_slice.sv
// DIGIT-bit ripple adder slice; the only adder in the subtraction datapath.
module sub_digit_slice #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    localparam int unsigned SW = DIGIT + 1;

    assign {cout, sum} = SW'(x) + SW'(y) + SW'(cin);

endmodule

// File: rtl/sub_serial_cmp.sv
// Multi-cycle signed/unsigned A-B: DIGIT bits per cycle through one slice,
// then a fix-up cycle producing |A-B| and exactly one of gt/eq/lt.
module sub_serial_cmp
    import sub_serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_mag,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned STEPS = steps(WIDTH, DIGIT);
    localparam int unsigned IW    = STEPS * DIGIT;
    localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_param
            $error("sub_serial_cmp: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    state_t           state;
    logic [IW-1:0]    a_sh;
    logic [IW-1:0]    b_sh;
    logic [IW-1:0]    d_r;
    logic             carry;
    logic [KW-1:0]    k;
    logic [DIGIT-1:0] sum;
    logic             cout;
    logic             neg;
    logic             d_nz;
    logic [WIDTH-1:0] d_lo;
    logic [WIDTH-1:0] mag;

    // Extension to IW bits keeps bit IW-1 a valid sign for any A-B.
    function automatic logic [IW-1:0] ext(input logic [WIDTH-1:0] v, input logic u);
        return u ? {{(IW-WIDTH){1'b0}}, v} : {{(IW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    sub_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    // |D| fits in WIDTH bits, so negating only the low bits is exact.
    assign neg  = d_r[IW-1];
    assign d_nz = |d_r;
    assign d_lo = d_r[WIDTH-1:0];
    assign mag  = neg ? (~d_lo + WIDTH'(1)) : d_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff_mag  <= '0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            k         <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            d_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= ext(a, is_unsigned);
                        b_sh     <= ~ext(b, is_unsigned);
                        carry    <= 1'b1;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // Operands shift down one digit per cycle; digit k of D
                    // lands at bits [k*DIGIT +: DIGIT] after the last shift.
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    d_r   <= {sum, d_r[IW-1:DIGIT]};
                    carry <= cout;
                    k     <= k + KW'(1);
                    if (k == KW'(STEPS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    diff_mag  <= mag;
                    gt        <= !neg && d_nz;
                    eq        <= !d_nz;
                    lt        <= neg;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_cmp.sv
// Scoreboard bench for sub_serial_cmp: main 8/2 instance plus a DIGIT/WIDTH sweep.
module tb_sub_serial_cmp;

    typedef struct {
        logic [7:0] mag;
        logic       gt;
        logic       eq;
        logic       lt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       is_unsigned;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff_mag;
    logic       gt;
    logic       eq;
    logic       lt;

    logic       sw_valid;
    logic       sw_ready;
    logic [7:0] sw_a;
    logic [7:0] sw_b;
    logic [3:0] sw_a4;
    logic [3:0] sw_b4;
    logic [3:0] sw_ir;
    logic [3:0] sw_ov;
    logic [3:0] sw_gt;
    logic [3:0] sw_eq;
    logic [3:0] sw_lt;
    logic [7:0] sw_mag [3];
    logic [3:0] w4_mag;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sub_serial_cmp #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_unsigned(is_unsigned), .out_valid(out_valid),
        .out_ready(out_ready), .diff_mag(diff_mag), .gt(gt), .eq(eq), .lt(lt)
    );

    sub_serial_cmp #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[0]),
        .a(sw_a), .b(sw_b), .is_unsigned(1'b0), .out_valid(sw_ov[0]),
        .out_ready(sw_ready), .diff_mag(sw_mag[0]), .gt(sw_gt[0]), .eq(sw_eq[0]), .lt(sw_lt[0])
    );

    sub_serial_cmp #(.WIDTH(8), .DIGIT(3)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[1]),
        .a(sw_a), .b(sw_b), .is_unsigned(1'b0), .out_valid(sw_ov[1]),
        .out_ready(sw_ready), .diff_mag(sw_mag[1]), .gt(sw_gt[1]), .eq(sw_eq[1]), .lt(sw_lt[1])
    );

    sub_serial_cmp #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[2]),
        .a(sw_a), .b(sw_b), .is_unsigned(1'b0), .out_valid(sw_ov[2]),
        .out_ready(sw_ready), .diff_mag(sw_mag[2]), .gt(sw_gt[2]), .eq(sw_eq[2]), .lt(sw_lt[2])
    );

    sub_serial_cmp #(.WIDTH(4), .DIGIT(1)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[3]),
        .a(sw_a4), .b(sw_b4), .is_unsigned(1'b0), .out_valid(sw_ov[3]),
        .out_ready(sw_ready), .diff_mag(w4_mag), .gt(sw_gt[3]), .eq(sw_eq[3]), .lt(sw_lt[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic u);
        longint sa, sbv, d;
        exp_t   r;
        sa    = u ? longint'(av) : longint'($signed(av));
        sbv   = u ? longint'(bv) : longint'($signed(bv));
        d     = sa - sbv;
        r.mag = 8'(d < 0 ? -d : d);
        r.gt  = d > 0;
        r.eq  = d == 0;
        r.lt  = d < 0;
        return r;
    endfunction

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic u);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a           = av;
        b           = bv;
        is_unsigned = u;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(av, bv, u));
    endtask

    task automatic wait_result(input int exp_lat);
        int cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic pop_cmp();
        exp_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("diff_mag", 32'(diff_mag), 32'(e.mag));
            check("gt", 32'(gt), 32'(e.gt));
            check("eq", 32'(eq), 32'(e.eq));
            check("lt", 32'(lt), 32'(e.lt));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic u);
        send(av, bv, u);
        wait_result(6);
        pop_cmp();
        handshake();
    endtask

    initial begin
        logic [7:0] held_mag;
        int         lat[4];
        logic [7:0] cap_mag[4];
        logic [3:0] cap_lt;
        int         lat_exp[4] = '{10, 4, 3, 6};
        logic [7:0] mag_exp[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h02};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_unsigned = 1'b0;
        sw_valid = 1'b0; sw_ready = 1'b1;
        sw_a = '0; sw_b = '0; sw_a4 = '0; sw_b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff_mag", 32'(diff_mag), 32'd0);
        check("rst_flags", 32'({gt, eq, lt}), 32'd0);
        rst_n = 1'b1;

        // A stray out_ready in IDLE must not disturb anything.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_out_ready_ov", 32'(out_valid), 32'd0);
        check("idle_out_ready_ir", 32'(in_ready), 32'd1);

        do_op(8'h05, 8'hFD, 1'b0);
        do_op(8'h80, 8'h7F, 1'b0);
        do_op(8'h80, 8'h7F, 1'b1);
        do_op(8'h3C, 8'h3C, 1'b0);
        do_op(8'h3C, 8'h3C, 1'b1);
        do_op(8'h7F, 8'h80, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1);
        do_op(8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Backpressure: result must hold while in_valid/a/b toggle.
        send(8'h12, 8'hF0, 1'b0);
        wait_result(6);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            if (sb.size() != 0) begin
                check("bp_diff_mag", 32'(diff_mag), 32'(sb[0].mag));
                check("bp_flags", 32'({gt, eq, lt}), 32'({sb[0].gt, sb[0].eq, sb[0].lt}));
            end
        end
        in_valid = 1'b0;
        held_mag = diff_mag;
        pop_cmp();
        handshake();
        check("hs_mag_retained", 32'(diff_mag), 32'(held_mag));
        check("hs_gt_retained", 32'(gt), 32'd1);

        // Reset during the second CALC cycle discards the operation.
        send(8'h55, 8'h11, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff_mag", 32'(diff_mag), 32'd0);
        check("midrst_flags", 32'({gt, eq, lt}), 32'd0);
        rst_n = 1'b1;
        sb.delete();
        do_op(8'h10, 8'h20, 1'b0);

        // Parameter sweep: -128 - 127 on WIDTH=8, and 3 - 5 on WIDTH=4.
        sw_a  = 8'h80;
        sw_b  = 8'h7F;
        sw_a4 = 4'h3;
        sw_b4 = 4'h5;
        check("sw_all_ready", 32'(sw_ir), 32'hF);
        sw_valid = 1'b1;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            lat[j] = 0;
            cap_mag[j] = '0;
        end
        cap_lt = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                if (sw_ov[j] && lat[j] == 0) begin
                    lat[j]     = cyc;
                    cap_mag[j] = (j == 3) ? 8'(w4_mag) : sw_mag[j];
                    cap_lt[j]  = sw_lt[j] && !sw_gt[j] && !sw_eq[j];
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("sweep%0d_latency", j), 32'(lat[j]), 32'(lat_exp[j]));
            check($sformatf("sweep%0d_diff_mag", j), 32'(cap_mag[j]), 32'(mag_exp[j]));
            check($sformatf("sweep%0d_lt_only", j), 32'(cap_lt[j]), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
